// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle RV64 control unit: opcodes, state encoding,
// register-file write-back source codes and the bundled control vector.
package control_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_MEM    = 3'd5;
    localparam logic [2:0] ST_WB     = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    typedef enum logic [2:0] {
        S_RESET  = ST_RESET,
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

    localparam logic [1:0] SEL_DM    = 2'b00;
    localparam logic [1:0] SEL_ULA   = 2'b01;
    localparam logic [1:0] SEL_PC4   = 2'b10;
    localparam logic [1:0] SEL_PCIMM = 2'b11;

    typedef struct packed {
        logic       sub;
        logic       we_rf;
        logic       we_mem;
        logic [1:0] rf_din_sel;
        logic       ula_din2_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_next_sel;
        logic       pc_adder_sel;
        logic       reset_ir;
        logic       halted;
    } ctrl_t;

    function automatic logic is_supported(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE,
                          OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC};
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction fields in, datapath control strobes out; the control unit is the master.
interface control_unit_if;

    logic       run;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;

    logic       sub;
    logic       WE_RF;
    logic       WE_MEM;
    logic [1:0] RF_din_sel;
    logic       ULA_din2_sel;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic       reset_ir;
    logic       halted;
    logic       illegal;

    modport master (
        input  run, opcode, funct3, funct7_5,
        output sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
               pc_next_sel, pc_adder_sel, reset_ir, halted, illegal
    );

    modport slave (
        output run, opcode, funct3, funct7_5,
        input  sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
               pc_next_sel, pc_adder_sel, reset_ir, halted, illegal
    );

endinterface

// File: rtl/control_unit_decoder.sv
// Moore output decode: control vector from the current state and the instruction
// fields latched in DECODE.
module control_decoder
    import control_unit_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl
);

    logic uses_imm;
    logic sub_op;

    assign uses_imm = opcode inside {OP_IMM, OP_LOAD, OP_STORE, OP_JALR};
    assign sub_op   = (opcode == OP_BRANCH) ||
                      (opcode == OP_R && funct3 == 3'b000 && funct7_5);

    // ULA controls stay asserted through MEM and WB so the result being written stays valid.
    always_comb begin
        ctrl = '0;
        case (state)
            S_RESET: begin
                ctrl.reset_pc = 1'b1;
                ctrl.reset_ir = 1'b1;
            end
            S_EXEC: begin
                ctrl.sub          = sub_op;
                ctrl.ula_din2_sel = uses_imm;
                if (opcode == OP_BRANCH) begin
                    ctrl.pc_next_sel = 1'b1;
                    ctrl.load_pc     = 1'b1;
                end
            end
            S_MEM: begin
                ctrl.sub          = sub_op;
                ctrl.ula_din2_sel = uses_imm;
                if (opcode == OP_STORE) begin
                    ctrl.we_mem  = 1'b1;
                    ctrl.load_pc = 1'b1;
                end
            end
            S_WB: begin
                ctrl.sub          = sub_op;
                ctrl.ula_din2_sel = uses_imm;
                ctrl.we_rf        = 1'b1;
                ctrl.load_pc      = 1'b1;
                ctrl.pc_next_sel  = (opcode == OP_JAL) || (opcode == OP_JALR);
                ctrl.pc_adder_sel = (opcode == OP_JALR);
                case (opcode)
                    OP_LOAD:         ctrl.rf_din_sel = SEL_DM;
                    OP_JAL, OP_JALR: ctrl.rf_din_sel = SEL_PC4;
                    OP_AUIPC:        ctrl.rf_din_sel = SEL_PCIMM;
                    default:         ctrl.rf_din_sel = SEL_ULA;
                endcase
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the single-issue RV64 datapath:
// RESET -> IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, HALT on illegal opcode.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int FETCH_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    control_unit_if.master    bus
);

    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT);

    state_t     state;
    state_t     next_state;
    logic [1:0] wait_cnt;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    logic       funct7_5_q;
    logic       illegal_q;
    ctrl_t      ctrl;

    // Fields are captured once in DECODE so later stages never see the live IR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_RESET;
            wait_cnt   <= 2'd0;
            opcode_q   <= 7'd0;
            funct3_q   <= 3'd0;
            funct7_5_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == S_FETCH && next_state == S_FETCH) ? wait_cnt + 2'd1 : 2'd0;
            if (state == S_DECODE) begin
                opcode_q   <= bus.opcode;
                funct3_q   <= bus.funct3;
                funct7_5_q <= bus.funct7_5;
                if (!is_supported(bus.opcode)) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_IDLE;
            S_IDLE:   if (bus.run) next_state = S_FETCH;
            S_FETCH:  if (wait_cnt == WAIT_LAST) next_state = S_DECODE;
            S_DECODE: next_state = is_supported(bus.opcode) ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (opcode_q == OP_BRANCH) begin
                    next_state = S_FETCH;
                end else if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM:    next_state = (opcode_q == OP_STORE) ? S_FETCH : S_WB;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_RESET;
        endcase
    end

    control_decoder u_decoder (
        .state    (state),
        .opcode   (opcode_q),
        .funct3   (funct3_q),
        .funct7_5 (funct7_5_q),
        .ctrl     (ctrl)
    );

    assign bus.sub          = ctrl.sub;
    assign bus.WE_RF        = ctrl.we_rf;
    assign bus.WE_MEM       = ctrl.we_mem;
    assign bus.RF_din_sel   = ctrl.rf_din_sel;
    assign bus.ULA_din2_sel = ctrl.ula_din2_sel;
    assign bus.load_pc      = ctrl.load_pc;
    assign bus.reset_pc     = ctrl.reset_pc;
    assign bus.pc_next_sel  = ctrl.pc_next_sel;
    assign bus.pc_adder_sel = ctrl.pc_adder_sel;
    assign bus.reset_ir     = ctrl.reset_ir;
    assign bus.halted       = ctrl.halted;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model expands each opcode into its
// per-cycle control trace; literal pins fix key cycles independently of that model.
module tb_control_unit;

    localparam int FW = 1;

    localparam logic [6:0] R_OP     = 7'b0110011;
    localparam logic [6:0] IMM_OP   = 7'b0010011;
    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;
    localparam logic [6:0] BR_OP    = 7'b1100011;
    localparam logic [6:0] JAL_OP   = 7'b1101111;
    localparam logic [6:0] JALR_OP  = 7'b1100111;
    localparam logic [6:0] AUIPC_OP = 7'b0010111;
    localparam logic [6:0] BAD_OP   = 7'b1111111;

    typedef struct packed {
        logic       sub;
        logic       we_rf;
        logic       we_mem;
        logic [1:0] rf_sel;
        logic       din2;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_next;
        logic       pc_adder;
        logic       reset_ir;
        logic       halted;
        logic       illegal;
    } exp_t;

    typedef struct {
        string name;
        exp_t  val;
    } pin_t;

    localparam exp_t RESET_V = 13'b000_00_0_0_1_0_0_1_0_0;
    localparam exp_t HALT_V  = 13'b000_00_0_0_0_0_0_0_1_1;

    logic clk = 1'b0;
    logic rst;
    control_unit_if bus ();

    control_unit #(.FETCH_WAIT(FW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    pin_t pin_q[$];
    exp_t trace_q[$];
    int   errors = 0;
    int   checks = 0;
    logic model_illegal;

    // Instruction-level model: fetch/decode padding, then the class-specific stage list.
    function automatic void build_trace(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        exp_t v;
        trace_q.delete();
        v = '0;
        v.illegal = model_illegal;
        for (int i = 0; i < 2 + FW; i++) trace_q.push_back(v);
        if (!(op inside {R_OP, IMM_OP, LOAD_OP, STORE_OP, BR_OP, JAL_OP, JALR_OP, AUIPC_OP})) begin
            model_illegal = 1'b1;
            return;
        end
        v.sub  = (op == BR_OP) || (op == R_OP && f3 == 3'b000 && f7);
        v.din2 = op inside {IMM_OP, LOAD_OP, STORE_OP, JALR_OP};
        if (op == BR_OP) begin
            v.pc_next = 1'b1;
            v.load_pc = 1'b1;
            trace_q.push_back(v);
            return;
        end
        trace_q.push_back(v);
        if (op == STORE_OP) begin
            v.we_mem  = 1'b1;
            v.load_pc = 1'b1;
            trace_q.push_back(v);
            return;
        end
        if (op == LOAD_OP) trace_q.push_back(v);
        v.we_rf    = 1'b1;
        v.load_pc  = 1'b1;
        v.pc_next  = (op == JAL_OP) || (op == JALR_OP);
        v.pc_adder = (op == JALR_OP);
        if (op == LOAD_OP)                         v.rf_sel = 2'b00;
        else if (op == JAL_OP || op == JALR_OP)    v.rf_sel = 2'b10;
        else if (op == AUIPC_OP)                   v.rf_sel = 2'b11;
        else                                       v.rf_sel = 2'b01;
        trace_q.push_back(v);
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.sub      = bus.sub;
        s.we_rf    = bus.WE_RF;
        s.we_mem   = bus.WE_MEM;
        s.rf_sel   = bus.RF_din_sel;
        s.din2     = bus.ULA_din2_sel;
        s.load_pc  = bus.load_pc;
        s.reset_pc = bus.reset_pc;
        s.pc_next  = bus.pc_next_sel;
        s.pc_adder = bus.pc_adder_sel;
        s.reset_ir = bus.reset_ir;
        s.halted   = bus.halted;
        s.illegal  = bus.illegal;
        return s;
    endfunction

    task automatic checkOutput();
        exp_t act;
        exp_t e;
        pin_t p;
        act = sample();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("[TB] FAIL model_trace t=%0t actual=%b required=%b", $time, act, e);
            end
            checks++;
            if (act.we_rf === 1'b1 && act.we_mem === 1'b1) begin
                errors++;
                $display("[TB] FAIL write_exclusive t=%0t actual=11 required=not both", $time);
            end
        end
        while (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            checks++;
            if (act !== p.val) begin
                errors++;
                $display("[TB] FAIL %s t=%0t actual=%b required=%b", p.name, $time, act, p.val);
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string n, input exp_t v);
        pin_t p;
        p.name = n;
        p.val  = v;
        pin_q.push_back(p);
    endtask

    // Fields are scrambled after DECODE so any use of the live IR shows up.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input int pin_at, input string pin_name, input exp_t pin_val,
                                 input int abort_at);
        exp_t tr[$];
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        build_trace(op, f3, f7);
        tr = trace_q;
        for (int i = 0; i < tr.size(); i++) begin
            if (i == FW + 2) begin
                bus.opcode   = ~op;
                bus.funct3   = ~f3;
                bus.funct7_5 = ~f7;
            end
            if (i == pin_at) pin(pin_name, pin_val);
            if (i == abort_at) rst = 1'b1;
            cyc(tr[i]);
            if (i == abort_at) break;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.opcode    = 7'd0;
        bus.funct3    = 3'd0;
        bus.funct7_5  = 1'b0;
        model_illegal = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pin("reset_cycle", RESET_V);
        cyc(RESET_V);
        bus.run = 1'b1;
        pin("idle_cycle", '0);
        cyc('0);
        bus.run = 1'b0;

        applyStimulus(R_OP,     3'b000, 1'b1, FW + 2, "r_sub_exec",  13'b100_00_0_0_0_0_0_0_0_0, -1);
        applyStimulus(R_OP,     3'b000, 1'b1, FW + 3, "r_sub_wb",    13'b110_01_0_1_0_0_0_0_0_0, -1);
        applyStimulus(IMM_OP,   3'b000, 1'b1, -1,     "",            '0,                         -1);
        applyStimulus(LOAD_OP,  3'b011, 1'b0, FW + 4, "load_wb",     13'b010_00_1_1_0_0_0_0_0_0, -1);
        applyStimulus(STORE_OP, 3'b011, 1'b0, FW + 3, "store_mem",   13'b001_00_1_1_0_0_0_0_0_0, -1);
        applyStimulus(BR_OP,    3'b000, 1'b0, FW + 2, "branch_exec", 13'b100_00_0_1_0_1_0_0_0_0, -1);
        applyStimulus(JAL_OP,   3'b101, 1'b0, -1,     "",            '0,                         -1);
        applyStimulus(JALR_OP,  3'b000, 1'b0, FW + 3, "jalr_wb",     13'b010_10_1_1_0_1_1_0_0_0, -1);
        applyStimulus(AUIPC_OP, 3'b110, 1'b1, FW + 3, "auipc_wb",    13'b010_11_0_1_0_0_0_0_0_0, -1);
        applyStimulus(R_OP,     3'b101, 1'b1, -1,     "",            '0,                         -1);
        applyStimulus(R_OP,     3'b000, 1'b0, -1,     "",            '0,                         -1);

        applyStimulus(STORE_OP, 3'b011, 1'b0, -1, "", '0, FW + 3);
        rst = 1'b0;
        pin("reset_after_store", RESET_V);
        cyc(RESET_V);
        pin("idle_after_store", '0);
        cyc('0);
        cyc('0);
        bus.run = 1'b1;
        cyc('0);
        bus.run = 1'b0;

        applyStimulus(BAD_OP, 3'b111, 1'b1, -1, "", '0, -1);
        bus.run = 1'b1;
        pin("halt_flags", HALT_V);
        repeat (20) cyc(HALT_V);
        rst = 1'b1;
        cyc(HALT_V);
        rst = 1'b0;
        model_illegal = 1'b0;
        pin("reset_after_halt", RESET_V);
        cyc(RESET_V);
        bus.run = 1'b0;
        pin("idle_after_halt", '0);
        cyc('0);
        cyc('0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM for the single-issue RV64 datapath. Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath control input: sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc, pc_next_sel, pc_adder_sel, reset_ir.
- Takes opcode/funct fields from the instruction register output.
- Sits beside the datapath in the top level.

Parameters:
- FETCH_WAIT, 1, extra cycles held in FETCH for the IR to capture a stable instruction (0..3).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- run  in  1  leave IDLE and start executing
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- sub  out  1  ULA subtract
- WE_RF  out  1  regfile write enable
- WE_MEM  out  1  data memory write enable
- RF_din_sel  out  2  00 DM_out, 01 ula, 10 PC+4, 11 PC+imm
- ULA_din2_sel  out  1  0 rs2, 1 immediate
- load_pc  out  1  PC update strobe
- reset_pc  out  1  PC preset
- pc_next_sel  out  1  0 PC+4, 1 secondary adder (branch target resolved by PC flags)
- pc_adder_sel  out  1  0 PC base, 1 rs1 base (JALR)
- reset_ir  out  1  IR clear
- halted  out  1  FSM in HALT
- illegal  out  1  sticky, set on unsupported opcode

Behaviour:
- States: RESET, IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- RST=1 at an edge forces RESET next cycle from any state, including mid-instruction. No write strobe may assert in the cycle RESET is entered.
- RESET lasts 1 cycle: reset_pc=1, reset_ir=1, all other outputs 0, then IDLE.
- IDLE: all outputs 0. run=1 -> FETCH.
- The IR loads every cycle. PC changes only on load_pc, so the instruction is stable from DECODE to the end of the instruction.
- FETCH: 1+FETCH_WAIT cycles, outputs 0, then DECODE.
- DECODE: latch opcode/funct3/funct7_5 into internal registers. All later outputs decode from the latched copy.
- Opcode class routing after DECODE:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111 -> EXEC.
  - Any other opcode -> HALT with illegal=1.
- EXEC:
  - ULA_din2_sel=1 for I-ALU, LOAD, STORE, JALR; 0 otherwise.
  - sub=1 for BRANCH, or for R with funct3=000 and funct7_5=1.
  - BRANCH: pc_next_sel=1, load_pc=1, then FETCH (3 cycles total, FETCH_WAIT=0).
  - LOAD/STORE -> MEM. All other classes -> WB.
- MEM:
  - ULA controls held from EXEC.
  - STORE: WE_MEM=1 for exactly 1 cycle, load_pc=1 (PC+4), then FETCH.
  - LOAD -> WB.
- WB:
  - WE_RF=1 for exactly 1 cycle and load_pc=1.
  - RF_din_sel: LOAD 00, R/I-ALU 01, JAL/JALR 10, AUIPC 11.
  - pc_next_sel=1 for JAL/JALR, else 0. pc_adder_sel=1 only for JALR.
  - Next state FETCH.
- Latency with FETCH_WAIT=0: ALU/JAL/JALR/AUIPC 4 cycles, STORE 4, LOAD 5, BRANCH 3.
- Exactly one load_pc pulse per instruction. WE_RF and WE_MEM are never high together.
- HALT: all strobes 0, halted=1. Exit only via RST. illegal clears only on RST.
- run is ignored outside IDLE.
- Outputs are combinational from the state register plus latched fields (Moore). No output depends on live opcode during EXEC/MEM/WB.

Decomposition:
- Shared package holds:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC
  - state encoding localparams
  - RF_din_sel codes: SEL_DM, SEL_ULA, SEL_PC4, SEL_PCIMM
- Optional sub-module control_decoder: a combinational function of (state, latched fields) producing the output vector. The FSM register and next-state logic stay in control_unit.

Test Plan:
- Pulse RST, then run=1 -> 1 cycle reset_pc=reset_ir=1, then FETCH. First instruction completes with exactly one load_pc.
- R-type sub (opcode 0110011, funct3 000, funct7_5 1) -> EXEC sub=1, ULA_din2_sel=0. WB on cycle 4 has WE_RF=1 and RF_din_sel=01.
- LOAD then STORE -> LOAD: WE_RF in cycle 5 with RF_din_sel=00. STORE: WE_MEM=1 in cycle 4, WE_RF=0 throughout.
- BRANCH 1100011 -> cycle 3 has sub=1, pc_next_sel=1, load_pc=1, no write enables. JALR -> WB has pc_adder_sel=1 and RF_din_sel=10.
- Opcode 1111111 -> HALT with halted=1, illegal=1. Strobes stay 0 for 20 cycles and run is ignored. RST clears both flags.
- RST asserted during MEM of a STORE -> next cycle in RESET, WE_MEM=0 that cycle and after, then IDLE.
